// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's control, instruction-memory and instruction-register
// signals into one bundle.
//   stall        : downstream instruction register cannot accept this cycle
//   redirect     : taken branch/jump/trap, restart fetch at redirect_pc
//   redirect_pc  : new fetch address (bit 0 ignored)
//   imem_resp    : memory has valid data for the address presented this cycle
//   imem_rdata   : instruction word, valid when imem_resp=1
//   imem_read    : fetch request to instruction memory
//   imem_address : fetch address, always halfword aligned
//   ir_load      : one-cycle load strobe for the instruction register
//   ir_in        : instruction word for the instruction register
//   ir_pc        : address of the delivered instruction plus 2
// The master modport is the fetch stage's view; slave is the surrounding
// pipeline/memory view.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        ir_load;
    logic [15:0] ir_in;
    logic [15:0] ir_pc;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_resp,
        input  imem_rdata,
        output imem_read,
        output imem_address,
        output ir_load,
        output ir_in,
        output ir_pc
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_resp,
        output imem_rdata,
        input  imem_read,
        input  imem_address,
        input  ir_load,
        input  ir_in,
        input  ir_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch unit. Presents the PC to instruction memory and streams
// returned words into the downstream instruction register at up to one per
// cycle. When the instruction register stalls while a word arrives, the word
// is parked in a hold buffer and memory is idled until it can be delivered.
// A redirect abandons whatever is in flight and restarts fetch at the new PC.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : fetch_stage_if.master (control, imem and IR signals)
// ---------------------------------------------------------------------------
module fetch_stage (
    input  logic           clk,
    input  logic           reset,
    fetch_stage_if.master  bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_hold;
    logic [15:0] w_pcPlus2;
    logic [15:0] w_redirectPc;
    logic        w_wordReady;

    // The PC is kept even at all times, so the address of the next sequential
    // instruction is simply PC+2, wrapping naturally in 16 bits.
    assign w_pcPlus2    = r_pc + 16'd2;
    assign w_redirectPc = {bus.redirect_pc[15:1], 1'b0};

    // A word is available for delivery either straight from memory while
    // fetching or from the hold buffer while holding.
    assign w_wordReady  = (r_state == HOLD) || bus.imem_resp;

    // Outputs are purely combinational so a returning word can be forwarded
    // to the instruction register in the same cycle it arrives. Reset and
    // redirect both suppress the load strobe so a discarded word never leaks.
    always_comb begin
        bus.imem_read    = (r_state == FETCH);
        bus.imem_address = {r_pc[15:1], 1'b0};
        bus.ir_in        = (r_state == HOLD) ? r_hold : bus.imem_rdata;
        bus.ir_pc        = w_pcPlus2;
        bus.ir_load      = !reset && !bus.redirect && !bus.stall && w_wordReady;
    end

    // State, PC and hold buffer update. Priority is reset, then redirect, then
    // normal sequencing. In FETCH a stalled response is captured into the hold
    // buffer and the PC is left pointing at it; the PC only advances once the
    // instruction has actually been handed to the instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= 16'h0000;
            r_hold  <= 16'h0000;
        end else if (bus.redirect) begin
            r_state <= FETCH;
            r_pc    <= w_redirectPc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_resp) begin
                        if (bus.stall) begin
                            r_hold  <= bus.imem_rdata;
                            r_state <= HOLD;
                        end else begin
                            r_pc    <= w_pcPlus2;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        r_pc    <= w_pcPlus2;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: a table of directed cycles with
// hand-derived expectations, a few multi-cycle corner sequences, then a
// randomized run checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        resp;
        logic [15:0] rdata;
        logic        expRead;
        logic [15:0] expAddr;
        logic        expLoad;
        logic [15:0] expIn;
        logic [15:0] expPc;
    } vec_t;

    logic clk;
    logic reset;
    fetch_stage_if bus ();

    int compared;
    int mismatched;

    // Reference model: the PC as a plain integer and the queue of words that
    // were accepted from memory but not yet delivered (at most one).
    int          mPc;
    logic [15:0] mPending[$];

    vec_t vecs[$];

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic rst, logic stall, logic redirect,
                                   logic [15:0] rpc, logic resp, logic [15:0] rdata,
                                   logic expRead, logic [15:0] expAddr,
                                   logic expLoad, logic [15:0] expIn,
                                   logic [15:0] expPc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redirect = redirect; v.rpc = rpc;
        v.resp = resp; v.rdata = rdata; v.expRead = expRead; v.expAddr = expAddr;
        v.expLoad = expLoad; v.expIn = expIn; v.expPc = expPc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Expected outputs derived from the model's view of the world.
    function automatic vec_t modelExpect(vec_t v);
        vec_t e;
        bit   haveWord;
        e = v;
        haveWord  = (mPending.size() > 0) || v.resp;
        e.expRead = (mPending.size() == 0);
        e.expAddr = 16'(mPc);
        e.expLoad = !v.rst && !v.redirect && !v.stall && haveWord;
        e.expIn   = (mPending.size() > 0) ? mPending[0] : v.rdata;
        e.expPc   = 16'((mPc + 2) % 65536);
        return e;
    endfunction

    task automatic modelUpdate(vec_t v);
        if (v.rst) begin
            mPc = 0;
            mPending.delete();
        end else if (v.redirect) begin
            mPc = int'(v.rpc) - (int'(v.rpc) % 2);
            mPending.delete();
        end else if (mPending.size() > 0) begin
            if (!v.stall) begin
                void'(mPending.pop_front());
                mPc = (mPc + 2) % 65536;
            end
        end else if (v.resp) begin
            if (v.stall) mPending.push_back(v.rdata);
            else         mPc = (mPc + 2) % 65536;
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check the combinational
    // outputs shortly after, then let the rising edge commit state.
    task automatic applyStimulus(input vec_t v, input bit useModel, input string tag);
        vec_t e;
        @(negedge clk);
        reset           = v.rst;
        bus.stall       = v.stall;
        bus.redirect    = v.redirect;
        bus.redirect_pc = v.rpc;
        bus.imem_resp   = v.resp;
        bus.imem_rdata  = v.rdata;
        #1;
        e = useModel ? modelExpect(v) : v;
        checkOutput({tag, " ir_load"}, {15'd0, bus.ir_load}, {15'd0, e.expLoad});
        if (!v.rst) begin
            checkOutput({tag, " imem_read"}, {15'd0, bus.imem_read}, {15'd0, e.expRead});
            if (e.expRead)
                checkOutput({tag, " imem_address"}, bus.imem_address, e.expAddr);
        end
        if (e.expLoad) begin
            checkOutput({tag, " ir_in"}, bus.ir_in, e.expIn);
            checkOutput({tag, " ir_pc"}, bus.ir_pc, e.expPc);
        end
        @(posedge clk);
        modelUpdate(v);
    endtask

    task automatic doReset();
        applyStimulus(mkVec(1,0,0,0,0,0, 0,0,0,0,0), 1'b0, "reset0");
    endtask

    initial begin
        vec_t v;
        compared   = 0;
        mismatched = 0;
        mPc        = 0;
        reset      = 1'b1;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
        bus.imem_resp = 0; bus.imem_rdata = 0;

        // Initial reset: state is unknown before the first edge, so the
        // first cycle is only checked for a suppressed load.
        doReset();

        // Directed table: rst,stall,redir,rpc,resp,rdata | read,addr,load,in,pc
        vecs.push_back(mkVec(1,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000));
        // streaming from 0x0000
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h1000, 1,16'h0000,1,16'h1000,16'h0002));
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h1002, 1,16'h0002,1,16'h1002,16'h0004));
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h1004, 1,16'h0004,1,16'h1004,16'h0006));
        // short memory wait at 0x0006
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'hDEAD, 1,16'h0006,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'hDEAD, 1,16'h0006,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h2222, 1,16'h0006,1,16'h2222,16'h0008));
        // stall capture at 0x0008
        vecs.push_back(mkVec(0,1,0,16'h0000,1,16'hABCD, 1,16'h0008,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,1,0,16'h0000,1,16'h0BAD, 0,16'h0000,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0BAD, 0,16'h0000,1,16'hABCD,16'h000A));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0000, 1,16'h000A,0,16'h0000,16'h0000));
        // redirect wins over a response in FETCH
        vecs.push_back(mkVec(0,0,1,16'h3001,1,16'h7777, 1,16'h000A,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0000, 1,16'h3000,0,16'h0000,16'h0000));
        // wrap at the top of the address space
        vecs.push_back(mkVec(0,0,1,16'hFFFF,0,16'h0000, 1,16'h3000,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h4321, 1,16'hFFFE,1,16'h4321,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000));
        // redirect while holding drops the held word
        vecs.push_back(mkVec(0,1,0,16'h0000,1,16'h9999, 1,16'h0000,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,1,16'h0100,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0000, 1,16'h0100,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,1,16'h1111, 1,16'h0100,1,16'h1111,16'h0102));
        // reset while holding 0x5555
        vecs.push_back(mkVec(0,1,0,16'h0000,1,16'h5555, 1,16'h0102,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(1,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000));
        vecs.push_back(mkVec(0,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000));

        foreach (vecs[i])
            applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Memory wait: five cycles without response at 0x0040, then one
        // response and exactly one load.
        applyStimulus(mkVec(0,0,1,16'h0040,0,0, 1,16'h0000,0,0,0), 1'b0, "wait redirect");
        for (int i = 0; i < 5; i++)
            applyStimulus(mkVec(0,0,0,0,0,16'hEEEE, 1,16'h0040,0,0,0), 1'b0,
                          $sformatf("wait%0d", i));
        applyStimulus(mkVec(0,0,0,0,1,16'h0440, 1,16'h0040,1,16'h0440,16'h0042), 1'b0, "wait resp");
        applyStimulus(mkVec(0,0,0,0,0,16'h0440, 1,16'h0042,0,0,0), 1'b0, "wait after");

        // Stall capture: three stalled cycles at 0x0010 then release.
        applyStimulus(mkVec(0,0,1,16'h0010,0,0, 1,16'h0042,0,0,0), 1'b0, "stall redirect");
        applyStimulus(mkVec(0,1,0,0,1,16'hABCD, 1,16'h0010,0,0,0), 1'b0, "stall0");
        for (int i = 1; i < 3; i++)
            applyStimulus(mkVec(0,1,0,0,0,0, 0,0,0,0,0), 1'b0, $sformatf("stall%0d", i));
        applyStimulus(mkVec(0,0,0,0,0,0, 0,0,1,16'hABCD,16'h0012), 1'b0, "stall release");
        applyStimulus(mkVec(0,0,0,0,0,0, 1,16'h0012,0,0,0), 1'b0, "stall refetch");

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            v = mkVec(0,0,0,0,0,0, 0,0,0,0,0);
            v.rst      = ($urandom_range(0, 49) == 0);
            v.stall    = ($urandom_range(0, 2) == 0);
            v.redirect = ($urandom_range(0, 11) == 0);
            v.rpc      = 16'($urandom);
            v.resp     = ($urandom_range(0, 3) != 0);
            v.rdata    = 16'($urandom);
            applyStimulus(v, 1'b1, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
